rmt_phv_fifo: RTL and testbench

//  Parametrised first-word-fall-through FIFO for packet header vectors (PHVs). It sits between
//  the last match-action stage and the deparser, and replaces fixed-width split PHV FIFOs.
//  A single full/empty view covers the whole vector. Adds overflow drop accounting, an

---
 rtl/rmt_pkg.sv | 23 ++
 rtl/rmt_sdp_ram.sv | 38 +++
 rtl/rmt_phv_fifo.sv | 127 ++++++++++++
 tb/tb_rmt_phv_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_pkg.sv
// Shared PHV layout: container block, metadata words and user scratch area.
// Field offsets are common to the parser, the match-action stages and the deparser.
package rmt_pkg;

    localparam int PHV_GRP_CNT   = 8;
    localparam int PHV_A_CNT     = 6;
    localparam int PHV_B_CNT     = 4;
    localparam int PHV_C_CNT     = 2;
    localparam int PHV_BYTE_W    = 8;
    localparam int PHV_CONT_W    = (PHV_A_CNT + PHV_B_CNT + PHV_C_CNT) * PHV_GRP_CNT * PHV_BYTE_W;
    localparam int PHV_META_CNT  = 20;
    localparam int PHV_META_WW   = 5;
    localparam int PHV_META_W    = PHV_META_CNT * PHV_META_WW;
    localparam int PHV_USER_W    = 256;

    localparam int PHV_CONT_OFF  = 0;
    localparam int PHV_META_OFF  = PHV_CONT_OFF + PHV_CONT_W;
    localparam int PHV_USER_OFF  = PHV_META_OFF + PHV_META_W;
    localparam int PHV_WIDTH     = PHV_USER_OFF + PHV_USER_W;

    typedef logic [PHV_WIDTH-1:0] phv_t;

endpackage

// File: rtl/rmt_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port with registered read data.
// Latency: read data appears one cycle after rd_en; read-first on an address collision.
// Backpressure: none; rd_dat holds its value while rd_en is low.
module rmt_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_dat;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_dat;
        end
    end

    // Only the output register is reset; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_rd_dat <= '0;
        end else if (rd_en) begin
            r_rd_dat <= r_mem[rd_addr];
        end
    end

    assign rd_dat = r_rd_dat;

endmodule

// File: rtl/rmt_phv_fifo.sv
// First-word-fall-through PHV FIFO between the last match-action stage and the deparser.
// Latency: a push into an empty FIFO is visible on phv_out two cycles later.
// Backpressure: no input ready; pushes beyond DEPTH+1 entries are dropped and counted.
module rmt_phv_fifo #(
    parameter int PHV_WIDTH    = rmt_pkg::PHV_WIDTH,
    parameter int DEPTH        = 32,
    parameter int AFULL_THRESH = 24,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       flush,
    input  logic [PHV_WIDTH-1:0]       phv_in,
    input  logic                       phv_in_valid,
    output logic [PHV_WIDTH-1:0]       phv_out,
    output logic                       phv_out_valid,
    input  logic                       phv_out_ready,
    output logic [$clog2(DEPTH)+1:0]   fill_level,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH) + 2;

    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [FW-1:0]         r_fill;
    logic                  r_out_valid;
    logic                  r_afull;
    logic                  r_ovf;
    logic [CNT_WIDTH-1:0]  r_drop;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_drop;
    logic                  w_ram_empty;
    logic                  w_prefetch;
    logic [FW-1:0]         w_fill_nxt;

    assign w_push      = phv_in_valid & ~flush;
    assign w_pop       = r_out_valid & phv_out_ready;
    assign w_full      = (r_fill == FW'(DEPTH + 1)) & ~w_pop;
    assign w_wr_en     = w_push & ~w_full;
    assign w_drop      = w_push & w_full;
    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);

    // The RAM read register doubles as the output register, so a read is
    // only issued when the head slot is free or being vacated this cycle.
    assign w_prefetch  = (~r_out_valid | w_pop) & ~w_ram_empty & ~flush;

    always_comb begin
        w_fill_nxt = r_fill;
        case ({w_wr_en, w_pop})
            2'b10:   w_fill_nxt = r_fill + FW'(1);
            2'b01:   w_fill_nxt = r_fill - FW'(1);
            default: w_fill_nxt = r_fill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_afull     <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_afull     <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (w_prefetch) begin
                r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
            end
            if (w_prefetch) begin
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            r_fill  <= w_fill_nxt;
            r_afull <= (w_fill_nxt >= FW'(AFULL_THRESH));
        end
    end

    // Drop accounting survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else begin
            r_ovf <= w_drop;
            if (w_drop && (r_drop != {CNT_WIDTH{1'b1}})) begin
                r_drop <= r_drop + CNT_WIDTH'(1);
            end
        end
    end

    rmt_sdp_ram #(
        .WIDTH (PHV_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr[AW-1:0]),
        .wr_dat  (phv_in),
        .rd_en   (w_prefetch),
        .rd_addr (r_rd_ptr[AW-1:0]),
        .rd_dat  (phv_out)
    );

    assign phv_out_valid = r_out_valid;
    assign fill_level    = r_fill;
    assign almost_full   = r_afull;
    assign overflow      = r_ovf;
    assign drop_cnt      = r_drop;

endmodule

// File: tb/tb_rmt_phv_fifo.sv
// Directed bench for rmt_phv_fifo: a default-sized instance plus a small
// DEPTH=4 / CNT_WIDTH=4 instance for drop counter saturation.
module tb_rmt_phv_fifo;

    localparam int W  = 1124;
    localparam int W2 = 16;

    logic            clk = 1'b0;
    always #5 clk = ~clk;

    logic            aresetn;
    logic            flush;
    logic [W-1:0]    phv_in;
    logic            phv_in_valid;
    logic [W-1:0]    phv_out;
    logic            phv_out_valid;
    logic            phv_out_ready;
    logic [6:0]      fill_level;
    logic            almost_full;
    logic            overflow;
    logic [31:0]     drop_cnt;

    logic            aresetn2;
    logic [W2-1:0]   phv_in2;
    logic            phv_in_valid2;
    logic [W2-1:0]   phv_out2;
    logic            phv_out_valid2;
    logic [3:0]      fill_level2;
    logic            almost_full2;
    logic            overflow2;
    logic [3:0]      drop_cnt2;

    rmt_phv_fifo #(
        .PHV_WIDTH(W), .DEPTH(32), .AFULL_THRESH(24), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .aresetn(aresetn), .flush(flush),
        .phv_in(phv_in), .phv_in_valid(phv_in_valid),
        .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_ready(phv_out_ready),
        .fill_level(fill_level), .almost_full(almost_full),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    rmt_phv_fifo #(
        .PHV_WIDTH(W2), .DEPTH(4), .AFULL_THRESH(3), .CNT_WIDTH(4)
    ) dut2 (
        .clk(clk), .aresetn(aresetn2), .flush(1'b0),
        .phv_in(phv_in2), .phv_in_valid(phv_in_valid2),
        .phv_out(phv_out2), .phv_out_valid(phv_out_valid2), .phv_out_ready(1'b0),
        .fill_level(fill_level2), .almost_full(almost_full2),
        .overflow(overflow2), .drop_cnt(drop_cnt2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] q[$];
    int ovf_cnt;
    int pops;
    int max_fill;

    initial begin
        aresetn = 1'b0; flush = 1'b0; phv_in = '0; phv_in_valid = 1'b0; phv_out_ready = 1'b0;
        aresetn2 = 1'b0; phv_in2 = '0; phv_in_valid2 = 1'b0;
        repeat (3) tick();

        check("rst_valid", phv_out_valid, 0);
        check("rst_out",   phv_out, 0);
        check("rst_fill",  fill_level, 0);
        check("rst_afull", almost_full, 0);
        check("rst_ovf",   overflow, 0);
        check("rst_drop",  drop_cnt, 0);
        check("rst2_fill", fill_level2, 0);
        check("rst2_drop", drop_cnt2, 0);
        aresetn = 1'b1; aresetn2 = 1'b1;
        tick();

        // Latency: pushes 1,2,3 with no pops
        phv_in_valid = 1'b1; phv_in = W'(1); tick();
        phv_in = W'(2); tick();
        check("t1_valid_n2", phv_out_valid, 1);
        check("t1_out_n2",   phv_out, 1);
        check("t1_fill_n2",  fill_level, 2);
        phv_in = W'(3); tick();
        phv_in_valid = 1'b0;
        check("t1_fill_n3",  fill_level, 3);
        check("t1_out_hold", phv_out, 1);

        aresetn = 1'b0; tick(); aresetn = 1'b1; tick();
        check("t2_fill0", fill_level, 0);

        // Overfill: 40 pushes, 33 stored, 7 dropped
        ovf_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            phv_in_valid = 1'b1; phv_in = W'(n);
            tick();
            ovf_cnt += int'(overflow);
            if (n == 23) check("t2_afull_23", almost_full, 0);
            if (n == 24) check("t2_afull_24", almost_full, 1);
            if (n == 33) check("t2_fill_33", fill_level, 33);
        end
        phv_in_valid = 1'b0;
        tick();
        check("t2_ovf_idle",  overflow, 0);
        check("t2_ovf_pulses", W'(ovf_cnt), 7);
        check("t2_drop",      drop_cnt, 7);
        check("t2_fill",      fill_level, 33);
        check("t2_afull",     almost_full, 1);
        check("t2_head",      phv_out, 1);

        // Push and pop together while full
        phv_in_valid = 1'b1; phv_in = W'(41); phv_out_ready = 1'b1;
        check("t3_head_pre", phv_out, 1);
        tick();
        phv_in_valid = 1'b0;
        check("t3_fill", fill_level, 33);
        check("t3_drop", drop_cnt, 7);
        check("t3_ovf",  overflow, 0);
        for (int i = 0; i < 33; i++) begin
            check("t3_pop_valid", phv_out_valid, 1);
            check("t3_pop_dat",   phv_out, (i < 32) ? W'(i + 2) : W'(41));
            tick();
        end
        check("t3_empty_valid", phv_out_valid, 0);
        check("t3_empty_fill",  fill_level, 0);
        check("t3_afull_off",   almost_full, 0);

        // Streaming with continuous pops
        pops = 0; max_fill = 0;
        for (int c = 0; c < 1000; c++) begin
            if (phv_out_valid) begin
                check("t4_qsize", W'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    check("t4_dat", phv_out, q[0]);
                    void'(q.pop_front());
                end
                pops++;
            end
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            phv_in_valid = 1'b1; phv_in = W'(1000 + c);
            q.push_back(W'(1000 + c));
            tick();
        end
        phv_in_valid = 1'b0;
        check("t4_throughput", W'(pops), 998);
        for (int d = 0; d < 4; d++) begin
            if (phv_out_valid && q.size() != 0) begin
                check("t4_drain_dat", phv_out, q[0]);
                void'(q.pop_front());
                pops++;
            end
            tick();
        end
        check("t4_pops",     W'(pops), 1000);
        check("t4_maxfill",  W'(max_fill <= 3), 1);
        check("t4_q_empty",  W'(q.size()), 0);
        check("t4_fill_end", fill_level, 0);
        check("t4_drop",     drop_cnt, 7);

        // Flush with a concurrent push
        phv_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            phv_in_valid = 1'b1; phv_in = W'(256 + i); tick();
        end
        phv_in_valid = 1'b0;
        tick();
        check("t5_fill10", fill_level, 10);
        flush = 1'b1; phv_in_valid = 1'b1; phv_in = W'(16'hdead);
        tick();
        flush = 1'b0; phv_in_valid = 1'b0;
        check("t5_fill0",  fill_level, 0);
        check("t5_valid0", phv_out_valid, 0);
        check("t5_afull0", almost_full, 0);
        check("t5_ovf0",   overflow, 0);
        check("t5_drop",   drop_cnt, 7);
        phv_in_valid = 1'b1; phv_in = W'(8'h55); tick();
        phv_in_valid = 1'b0;
        check("t5_valid_n1", phv_out_valid, 0);
        tick();
        check("t5_valid_n2", phv_out_valid, 1);
        check("t5_head",     phv_out, 8'h55);
        check("t5_fill1",    fill_level, 1);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) begin
            phv_in_valid = 1'b1; phv_in = W'(8'h60 + i); tick();
        end
        phv_in_valid = 1'b0;
        check("t6_fill5", fill_level, 5);
        aresetn = 1'b0; tick(); aresetn = 1'b1;
        check("t6_valid", phv_out_valid, 0);
        check("t6_out",   phv_out, 0);
        check("t6_fill",  fill_level, 0);
        check("t6_afull", almost_full, 0);
        check("t6_ovf",   overflow, 0);
        check("t6_drop",  drop_cnt, 0);

        // Small instance: capacity 5, 4-bit drop counter
        for (int i = 0; i < 7; i++) begin
            phv_in_valid2 = 1'b1; phv_in2 = W2'(i + 1); tick();
        end
        phv_in_valid2 = 1'b0;
        check("t6b_drop2",  drop_cnt2, 2);
        check("t6b_fill5",  fill_level2, 5);
        check("t6b_afull",  almost_full2, 1);
        check("t6b_head",   phv_out2, 1);
        aresetn2 = 1'b0; tick(); aresetn2 = 1'b1;
        check("t6b_rst_drop",  drop_cnt2, 0);
        check("t6b_rst_fill",  fill_level2, 0);
        check("t6b_rst_valid", phv_out_valid2, 0);
        check("t6b_rst_out",   phv_out2, 0);
        check("t6b_rst_afull", almost_full2, 0);
        for (int i = 0; i < 25; i++) begin
            phv_in_valid2 = 1'b1; phv_in2 = W2'(i + 16'h100); tick();
            if (i == 19) check("t6b_drop15", drop_cnt2, 15);
        end
        check("t6b_ovf_sat", overflow2, 1);
        phv_in_valid2 = 1'b0;
        tick();
        check("t6b_sat",     drop_cnt2, 15);
        check("t6b_fill",    fill_level2, 5);
        check("t6b_head2",   phv_out2, 16'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
